// File: rtl/sar_adc_ctrl_if.sv
// rtl/sar_adc_ctrl_if.sv - soc/eoc start-of-conversion handshake with result bus
interface sar_adc_ctrl_if;
  logic       soc;
  logic       eoc;
  logic [7:0] x;

  modport master (output soc, input eoc, input x);
  modport slave  (input soc, output eoc, output x);
endinterface

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - 8-bit successive-approximation converter answering the soc/eoc handshake
module sar_adc_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clock,
  input  logic                 reset_,
  sar_adc_ctrl_if.slave        hs,
  output logic [7:0]           dac,
  input  logic                 cmp
);

  typedef enum logic [1:0] {IDLE, TRIAL, WAIT_SOC_LOW} state_e;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic        eoc_q, eoc_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  code_q, code_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  trial_code;
  logic [2:0]  idx_m1;

  assign idx_m1 = idx_q - 3'd1;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      eoc_q   <= 1'b1;
      x_q     <= 8'h00;
      code_q  <= 8'h00;
      idx_q   <= 3'd7;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      eoc_q   <= eoc_d;
      x_q     <= x_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    eoc_d      = eoc_q;
    x_d        = x_q;
    code_d     = code_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    trial_code = code_q;
    case (state_q)
      IDLE: begin
        if (hs.soc) begin
          eoc_d   = 1'b0;
          code_d  = 8'h80;
          idx_d   = 3'd7;
          cnt_d   = 4'd0;
          state_d = TRIAL;
        end
      end
      TRIAL: begin
        // Decision edge: resolve the bit under test and, in the same edge, present the next trial code.
        if (cnt_q == SETTLE_M1) begin
          if (!cmp) trial_code[idx_q] = 1'b0;
          if (idx_q != 3'd0) begin
            trial_code[idx_m1] = 1'b1;
            idx_d = idx_m1;
            cnt_d = 4'd0;
          end else begin
            state_d = WAIT_SOC_LOW;
          end
          code_d = trial_code;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_SOC_LOW: begin
        if (!hs.soc) begin
          x_d     = {~code_q[7], code_q[6:0]};
          eoc_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs.eoc = eoc_q;
  assign hs.x   = x_q;
  assign dac    = code_q;

endmodule
